// File: rtl/ahb3lite_req_arbiter.sv
// NREQ-way request arbiter driving one AHB3-Lite master port with SINGLE/INCR4 word transfers.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); otherwise round-robin.
module ahb3lite_req_arbiter #(
  parameter int NREQ = 2,
  parameter int AW   = 16,
  parameter int DW   = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ-1:0]      req_incr4,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic                 beat_valid,
  output logic [DW-1:0]        rdata,
  output logic                 done,
  output logic                 err,
  output logic [AW-1:0]        HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic [3:0]           HPROT,
  output logic [DW-1:0]        HWDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  input  logic [DW-1:0]        HRDATA
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR4  = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_ERRW, S_REJECT} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   win_q, win_d;
  logic [AW-1:0]   haddr_q, haddr_d;
  logic [1:0]      htrans_q, htrans_d;
  logic            hwrite_q, hwrite_d;
  logic [2:0]      hburst_q, hburst_d;
  logic [1:0]      arem_q, arem_d;   // address phases still to issue after the current one
  logic            dph_q, dph_d;     // a data phase is in progress this cycle
  logic [1:0]      dcnt_q, dcnt_d;   // data beats completed so far

  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [AW-1:0]   sel_addr;
  logic            sel_write, sel_incr4, reject, last_beat;

`ifdef AHB_ARB_FIXED_PRIO_EN
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req[i]) begin
        pick     = IW'(i);
        pick_vld = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] rr_q, rr_d;

  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_vld && req[idx[IW-1:0]]) begin
        pick     = idx[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  // Every transfer end (done, slave error, reject) passes the pointer beyond the last winner.
  always_comb begin
    rr_d = rr_q;
    if (done || err) rr_d = (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
  end
`endif

  assign sel_addr  = req_addr[int'(pick)*AW +: AW];
  assign sel_write = req_write[pick];
  assign sel_incr4 = req_incr4[pick];
  // Misaligned start, or an INCR4 that would run past a 1 KB boundary.
  assign reject    = (sel_addr[1:0] != 2'b00) || (sel_incr4 && (sel_addr[9:0] > 10'h3F0));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    win_d      = win_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hburst_d   = hburst_q;
    arem_d     = arem_q;
    dph_d      = dph_q;
    dcnt_d     = dcnt_q;
    beat_valid = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    last_beat  = hburst_q[0] ? (dcnt_q == 2'd3) : 1'b1;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          win_d = pick;
          if (reject) begin
            state_d = S_REJECT;
          end else begin
            state_d  = S_XFER;
            gnt_d    = NREQ'(1) << pick;
            haddr_d  = sel_addr;
            htrans_d = HT_NONSEQ;
            hwrite_d = sel_write;
            hburst_d = sel_incr4 ? HB_INCR4 : HB_SINGLE;
            arem_d   = sel_incr4 ? 2'd3 : 2'd0;
            dph_d    = 1'b0;
            dcnt_d   = 2'd0;
          end
        end
      end
      S_REJECT: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      S_XFER: begin
        if (dph_q && HRESP) begin
          htrans_d = HT_IDLE;
          if (HREADY) begin
            err     = 1'b1;
            state_d = S_IDLE;
            gnt_d   = '0;
            dph_d   = 1'b0;
          end else begin
            state_d = S_ERRW;
          end
        end else if (HREADY) begin
          if (htrans_q[1]) begin
            dph_d = 1'b1;
            if (arem_q != 2'd0) begin
              htrans_d = HT_SEQ;
              haddr_d  = haddr_q + AW'(4);
              arem_d   = arem_q - 2'd1;
            end else begin
              htrans_d = HT_IDLE;
            end
          end else begin
            dph_d = 1'b0;
          end
          if (dph_q) begin
            beat_valid = 1'b1;
            dcnt_d     = dcnt_q + 2'd1;
            if (last_beat) begin
              done     = 1'b1;
              state_d  = S_IDLE;
              gnt_d    = '0;
              htrans_d = HT_IDLE;
              dph_d    = 1'b0;
            end
          end
        end
      end
      S_ERRW: begin
        if (HREADY) begin
          err     = HRESP;
          state_d = S_IDLE;
          gnt_d   = '0;
          dph_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      win_q    <= '0;
      haddr_q  <= '0;
      htrans_q <= HT_IDLE;
      hwrite_q <= 1'b0;
      hburst_q <= HB_SINGLE;
      arem_q   <= 2'd0;
      dph_q    <= 1'b0;
      dcnt_q   <= 2'd0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      win_q    <= win_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hburst_q <= hburst_d;
      arem_q   <= arem_d;
      dph_q    <= dph_d;
      dcnt_q   <= dcnt_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign HADDR  = haddr_q;
  assign HTRANS = htrans_q;
  assign HWRITE = hwrite_q;
  assign HBURST = hburst_q;
  assign HSIZE  = 3'b010;
  assign HPROT  = 4'b0011;
  assign HWDATA = req_wdata[int'(win_q)*DW +: DW];
  assign rdata  = HRDATA;

endmodule

// File: doc/ahb3lite_req_arbiter.md
# ahb3lite_req_arbiter

Multi-requester front end for the single AHB3-Lite master port of the memory subsystem. Arbitrates between NREQ local requesters and drives one complete SINGLE or INCR4 word transfer per grant onto the bus. Handles pipelining, HREADY wait states and the two-cycle HRESP error response. Sits between the DMA/CPU-side request logic and the AHB-Lite slaves checked by the formal bus properties.

## Interface
- NREQ, 2, number of requesters (2..4)
- AW, 16, HADDR width
- DW, 32, data width; transfers are always word (HSIZE=3'b010)
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level; held until done or err
- req_addr  in  NREQ*AW  start address per requester
- req_write  in  NREQ  1=write
- req_incr4  in  NREQ  1=INCR4 burst, 0=SINGLE
- req_wdata  in  NREQ*DW  current write beat per requester
- gnt  out  NREQ  one-hot grant, held for the whole transfer
- beat_valid  out  1  a data phase completed OK this cycle; requester advances wdata / takes rdata
- rdata  out  DW  HRDATA passthrough, valid with beat_valid
- done  out  1  last beat completed OK
- err  out  1  transfer terminated: slave ERROR or rejected request
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA  out  AHB-Lite master outputs
- HREADY, HRESP, HRDATA  in  AHB-Lite master inputs

## Operation
- States: IDLE, XFER, ERRW, REJECT.
- IDLE: HTRANS=IDLE. If any req is set, pick a winner, register gnt, address, write and burst, then go to XFER. Rejection goes to REJECT instead: req_addr[1:0]!=0, or an INCR4 with addr[9:0]>10'h3F0 (would cross 1 KB).
- REJECT: err=1 for one cycle, gnt cleared, back to IDLE; no bus transfer issued.
- XFER, address side: the first beat drives NONSEQ. While more beats remain and HREADY=1, the next address phase drives SEQ with HADDR+4. After the last address is accepted, HTRANS=IDLE. HBURST=3'b000 (SINGLE) or 3'b011 (INCR4). HPROT=4'b0011.
- XFER, data side: a data phase is pending after each accepted address. On HREADY=1 and HRESP=0, beat_valid=1. On the fourth beat (or the only beat), done=1 as well, then go to IDLE and clear gnt.
- HWDATA = req_wdata of the granted requester, combinational.
- Error: HRESP=1 with HREADY=0 in a data phase is the first error cycle. Force HTRANS=IDLE from the next cycle, cancelling remaining beats, and go to ERRW.
- ERRW: on HREADY=1 and HRESP=1, err=1 and beat_valid=0. Clear gnt and go to IDLE.
- Arbitration: round-robin. The pointer moves to one past the last granted index when a transfer ends (done, err or reject).
- A requester dropping req mid-transfer is ignored.

## Timing
- Reset values: HTRANS=2'b00, HADDR=0, HWRITE=0, HBURST=0, HSIZE=3'b010, HPROT=4'b0011, gnt=0, done=0, err=0, beat_valid=0, state=IDLE, RR pointer=0.
- Bus outputs and gnt are registered. beat_valid, done, err (in ERRW) and rdata are combinational from HREADY/HRESP.
- Latency with zero wait states:
  - req high at edge N → gnt and NONSEQ at N+1.
  - SINGLE: done at N+2.
  - INCR4: SEQ at N+2..N+4, done at N+5.
- Wait states: HADDR, HTRANS and HWDATA hold while HREADY=0.
- Transfers are separated by at least one IDLE cycle; there is no NONSEQ pipelined across grants.
- Asynchronous reset mid-burst: all outputs return to reset values immediately, and the burst is abandoned with no done or err.

## Configuration
- AHB_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, RR pointer removed.
- AHB_ARB_FIXED_PRIO_EN undefined: round-robin as above.

## Test plan
- req=2'b01, addr 16'h0100, SINGLE read, HREADY=1 → NONSEQ at 16'h0100, HBURST=0, done and beat_valid one cycle later with rdata=HRDATA.
- req=2'b10, INCR4 write from 16'h0040, one wait state on beat 2 → HADDR sequence 40/44/44/48/4C, HWDATA held during the stall, 4 beat_valid pulses, done on the 4th.
- req=2'b11 held continuously, SINGLE each → grants alternate 01,10,01,10. With AHB_ARB_FIXED_PRIO_EN → always 01.
- INCR4 from 16'h0000, slave returns ERROR on beat 2 → HTRANS=IDLE from the 2nd error cycle, err=1 once, no done, only 1 beat_valid.
- Requests with req_addr=16'h0102, and INCR4 at 16'h03F4 → REJECT: err=1, HTRANS stays IDLE.
- HRESETn low during beat 3 of an INCR4 → HTRANS=0 and gnt=0 immediately; after release, the next req proceeds normally.
